serial_subtractor: RTL and testbench

//  Bit-serial, LSB-first subtractor. Computes diff = a - b and a borrow flag.

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/half_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for bit-serial arithmetic cells.
// State encoding and the serial bit-counter width function.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, borrow when a < b.
// Two of these chained form a full subtractor.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, one bit per clock.
// Result and borrow update only when the last bit retires.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Holds the WIDTH-1 bits already produced; the
  // current bit completes the word on the last cycle.
  logic [WIDTH-2:0] sd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bflop_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             done_q;
  logic             busy_q;

  logic             d0;
  logic             b0;
  logic             d;
  logic             b1;
  logic             bo;
  logic [WIDTH-1:0] word;

  half_subtractor u_hs0 (
    .a      (sa_q[0]),
    .b      (sb_q[0]),
    .diff   (d0),
    .borrow (b0)
  );

  half_subtractor u_hs1 (
    .a      (d0),
    .b      (bflop_q),
    .diff   (d),
    .borrow (b1)
  );

  assign bo   = b0 | b1;
  assign word = {d, sd_q};

  // FSM, shift datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      cnt_q    <= '0;
      bflop_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            bflop_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          sd_q    <= word[WIDTH-1:1];
          bflop_q <= bo;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            diff_q   <= word;
            borrow_q <= bo;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor (WIDTH 8 and 4).
// Results compared to plain modular arithmetic.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi,
                      output logic [7:0] d, output logic bo,
                      output int lat, output int nbusy,
                      output int nchg);
    logic [7:0] pd;
    logic       pb;
    pd     = diff8;
    pb     = borrow8;
    a8     = ai;
    b8     = bi;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    lat    = 0;
    nbusy  = 0;
    nchg   = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) nbusy++;
      if (diff8 !== pd || borrow8 !== pb) nchg++;
      step();
      lat++;
    end
    d  = diff8;
    bo = borrow8;
  endtask

  task automatic run4(input logic [3:0] ai, input logic [3:0] bi,
                      output logic [3:0] d, output logic bo,
                      output int lat, output int nchg);
    logic [3:0] pd;
    logic       pb;
    pd     = diff4;
    pb     = borrow4;
    a4     = ai;
    b4     = bi;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    lat    = 0;
    nchg   = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      if (diff4 !== pd || borrow4 !== pb) nchg++;
      step();
      lat++;
    end
    d  = diff4;
    bo = borrow4;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #3;
    n_chk++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8: got %b want 0",
               {busy8, done8, diff8, borrow8});
    end
    n_chk++;
    if ({busy4, done4, diff4, borrow4} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset4: got %b want 0",
               {busy4, done4, diff4, borrow4});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       bo;
    int lat, nb, nc;
    run8(8'd5, 8'd3, d, bo, lat, nb, nc);
    n_chk++;
    if (d !== 8'd2) begin
      n_fail++;
      $display("FAIL basic_diff: got %0d want 2", d);
    end
    n_chk++;
    if (bo !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_borrow: got %0d want 0", bo);
    end
    n_chk++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_chk++;
    if (nb != 8) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d want 8", nb);
    end
    n_chk++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_at_done: got %0d want 0", busy8);
    end
    step();
    n_chk++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %0d want 0", done8);
    end
  endtask

  task automatic test_values();
    logic [7:0] ta [6] = '{8'd3, 8'd0, 8'd0, 8'd255, 8'd0, 8'd128};
    logic [7:0] tb [6] = '{8'd5, 8'd1, 8'd0, 8'd0, 8'd255, 8'd128};
    logic [7:0] ai, bi, d;
    logic       bo;
    int lat, nb, nc, ed, eb;
    for (int i = 0; i < 40; i++) begin
      if (i < 6) begin
        ai = ta[i];
        bi = tb[i];
      end else begin
        ai = 8'($urandom);
        bi = 8'($urandom);
      end
      ed = (int'(ai) - int'(bi)) & 255;
      eb = (ai < bi) ? 1 : 0;
      run8(ai, bi, d, bo, lat, nb, nc);
      n_chk++;
      if (int'(d) != ed || int'(bo) != eb) begin
        n_fail++;
        $display("FAIL value %0d-%0d: got %0d/%0d want %0d/%0d",
                 ai, bi, d, bo, ed, eb);
      end
      n_chk++;
      if (lat != 8 || nc != 0) begin
        n_fail++;
        $display("FAIL value_timing %0d-%0d: got lat %0d chg %0d want 8/0",
                 ai, bi, lat, nc);
      end
      if (i[0]) step();
    end
    step();
  endtask

  task automatic test_ignore_start();
    int ndone, lat;
    logic [7:0] d;
    logic       bo;
    d = '0; bo = 1'b1; lat = -1; ndone = 0;
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done8 === 1'b1) begin
        ndone++;
        d   = diff8;
        bo  = borrow8;
        lat = 4 + i;
      end
      step();
    end
    n_chk++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d want 1", ndone);
    end
    n_chk++;
    if (d !== 8'd100 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got %0d/%0d want 100/0", d, bo);
    end
    n_chk++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d want 8", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    step();
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_chk++;
    if (lat != 8 || diff8 !== 8'd5 || borrow8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got lat %0d %0d/%0d want 8 5/0",
               lat, diff8, borrow8);
    end
    a8 = 8'd4; b8 = 8'd9;
    step();
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    start8 = 1'b0;
    n_chk++;
    if (lat + 1 != 9) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d want 9", lat + 1);
    end
    n_chk++;
    if (diff8 !== 8'd251 || borrow8 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d/%0d want 251/1",
               diff8, borrow8);
    end
    step();
    n_chk++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got done %0d busy %0d want 0/0",
               done8, busy8);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat, nb, nc;
    logic [7:0] d;
    logic       bo;
    a8 = 8'd7; b8 = 8'd2; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %b want 0",
               {busy8, done8, diff8, borrow8});
    end
    step(); step();
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d want 0", ndone);
    end
    run8(8'd7, 8'd2, d, bo, lat, nb, nc);
    n_chk++;
    if (d !== 8'd5 || bo !== 1'b0 || lat != 8) begin
      n_fail++;
      $display("FAIL midrst_rerun: got %0d/%0d lat %0d want 5/0 lat 8",
               d, bo, lat);
    end
    step();
  endtask

  task automatic test_w4_exhaustive();
    logic [3:0] d;
    logic       bo;
    int lat, nc, ed, eb;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        ed = (x - y) & 15;
        eb = (x < y) ? 1 : 0;
        run4(4'(x), 4'(y), d, bo, lat, nc);
        n_chk++;
        if (int'(d) != ed || int'(bo) != eb) begin
          n_fail++;
          $display("FAIL w4 %0d-%0d: got %0d/%0d want %0d/%0d",
                   x, y, d, bo, ed, eb);
        end
        n_chk++;
        if (lat != 4 || nc != 0) begin
          n_fail++;
          $display("FAIL w4_timing %0d-%0d: got lat %0d chg %0d want 4/0",
                   x, y, lat, nc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_w4_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
